spectrum_peak_matrix: RTL and testbench

- Downstream consumer of the spectrum display stage: takes the 8×8-bit band levels plus an update strobe and drives an 8×8 LED dot matrix as bar graphs with per-band peak-hold dots.
- Contains a level-to-height quantiser, a peak-hold/decay engine, and a frame shadow buffer so a frame never tears.
- Contains a multiplexed row scanner with one-cycle blanking at each row change.

---
 rtl/spectrum_peak_matrix.sv | 125 ++++++++++++
 tb/tb_spectrum_peak_matrix.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_matrix.sv
// rtl/spectrum_peak_matrix.sv - 8x8 LED bar-graph driver with per-band peak hold and tear-free frame snapshot
//
// Ports:
//   clk                 system clock, single domain
//   rst                 synchronous active-high reset
//   spectrum_data_flat  eight 8-bit band levels, band b at [8b+7:8b]
//   data_valid          one-cycle strobe marking spectrum_data_flat as new
//   row_n               active-low one-hot row select, row 0 = bottom
//   col_n               active-low column data, column b = band b
//   peak_flat           registered peak height per band, band b at [4b+3:4b]
//   frame_start         one-cycle pulse on the output cycle of row 0, dwell 0
module spectrum_peak_matrix #(
    parameter int SCAN_DIV   = 6250,
    parameter int TICK_DIV   = 2500000,
    parameter int HOLD_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] spectrum_data_flat,
    input  logic        data_valid,
    output logic [7:0]  row_n,
    output logic [7:0]  col_n,
    output logic [31:0] peak_flat,
    output logic        frame_start
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [3:0]    HOLD_INIT  = 4'(HOLD_TICKS);

    logic [DW-1:0]     dwell;
    logic [2:0]        row;
    logic [TW-1:0]     tick_cnt;
    logic [7:0][3:0]   height;
    logic [7:0][3:0]   peak;
    logic [7:0][3:0]   hold;
    logic [7:0][3:0]   shadow_height;
    logic [7:0][3:0]   shadow_peak;
    logic [7:0][3:0]   level_h;
    logic [7:0]        lit;
    logic              tick;
    logic              dwell_wrap;
    logic              frame_entry;

    assign tick        = (tick_cnt == TICK_LAST);
    assign dwell_wrap  = (dwell == DWELL_LAST);
    assign frame_entry = (dwell == '0) && (row == 3'd0);

    // Quantiser and per-column lit decision for the row currently scanned.
    always_comb begin
        level_h = '0;
        lit     = '0;
        for (int b = 0; b < 8; b++) begin
            if (spectrum_data_flat[8*b +: 8] == 8'd0) begin
                level_h[b] = 4'd0;
            end else begin
                level_h[b] = {1'b0, spectrum_data_flat[8*b+5 +: 3]} + 4'd1;
            end
            lit[b] = (shadow_height[b] > {1'b0, row}) ||
                     ((shadow_peak[b] != 4'd0) && (shadow_peak[b] == {1'b0, row} + 4'd1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell         <= '0;
            row           <= 3'd0;
            tick_cnt      <= '0;
            height        <= '0;
            peak          <= '0;
            hold          <= '0;
            shadow_height <= '0;
            shadow_peak   <= '0;
            row_n         <= 8'hFF;
            col_n         <= 8'hFF;
            peak_flat     <= '0;
            frame_start   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            dwell <= dwell_wrap ? '0 : dwell + 1'b1;
            if (dwell_wrap) begin
                row <= row + 3'd1;
            end

            if (data_valid) begin
                height <= level_h;
            end

            // A new peak (or equal) reloads hold and masks the tick for that band.
            for (int b = 0; b < 8; b++) begin
                if (data_valid && (level_h[b] >= peak[b])) begin
                    peak[b] <= level_h[b];
                    hold[b] <= HOLD_INIT;
                end else if (tick) begin
                    if (hold[b] != 4'd0) begin
                        hold[b] <= hold[b] - 4'd1;
                    end else if (peak[b] != 4'd0) begin
                        peak[b] <= peak[b] - 4'd1;
                    end
                end
            end

            peak_flat <= peak;

            // Snapshot uses pre-update values, so a coincident data_valid lands next frame.
            if (frame_entry) begin
                shadow_height <= height;
                shadow_peak   <= peak;
            end

            frame_start <= frame_entry;
            if (dwell == '0) begin
                row_n <= 8'hFF;
                col_n <= 8'hFF;
            end else begin
                row_n <= ~(8'd1 << row);
                col_n <= ~lit;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_matrix.sv
// tb/tb_spectrum_peak_matrix.sv - directed self-checking bench for spectrum_peak_matrix
module tb_spectrum_peak_matrix;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] spectrum_data_flat = '0;
    logic        data_valid = 1'b0;
    logic [7:0]  row_n;
    logic [7:0]  col_n;
    logic [31:0] peak_flat;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int e = 0;

    spectrum_peak_matrix #(
        .SCAN_DIV  (4),
        .TICK_DIV  (8),
        .HOLD_TICKS(2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .spectrum_data_flat(spectrum_data_flat),
        .data_valid        (data_valid),
        .row_n             (row_n),
        .col_n             (col_n),
        .peak_flat         (peak_flat),
        .frame_start       (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // e counts edges taken with rst low since the last reset edge.
    task automatic clk1();
        logic was_rst;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) e = 0;
        else e++;
    endtask

    task automatic goto(input int target);
        int guard;
        guard = 0;
        while (e < target && guard < 10000) begin
            clk1();
            guard++;
        end
        if (e != target) begin
            checks++;
            errors++;
            $display("FAIL goto: at edge %0d required %0d", e, target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_valid = 1'b0;
        spectrum_data_flat = '0;
        clk1();
        clk1();
        rst = 1'b0;
    endtask

    task automatic send(input logic [63:0] data);
        spectrum_data_flat = data;
        data_valid = 1'b1;
        clk1();
        data_valid = 1'b0;
    endtask

    initial begin
        // Reset release and idle scan
        for (int i = 0; i < 3; i++) begin
            clk1();
            check("rst_row_n", 32'(row_n), 32'hFF);
            check("rst_col_n", 32'(col_n), 32'hFF);
            check("rst_peak", peak_flat, 32'h0);
            check("rst_fs", 32'(frame_start), 32'h0);
        end
        rst = 1'b0;
        #2;
        check("post_rst_row_n", 32'(row_n), 32'hFF);
        check("post_rst_fs", 32'(frame_start), 32'h0);
        for (int i = 1; i <= 64; i++) begin
            clk1();
            check($sformatf("idle_fs_%0d", e), 32'(frame_start), 32'((e % 32) == 1));
            check($sformatf("idle_col_%0d", e), 32'(col_n), 32'hFF);
            if (e == 1)  check("idle_row_e1", 32'(row_n), 32'hFF);
            if (e == 2)  check("idle_row_e2", 32'(row_n), 32'hFE);
            if (e == 6)  check("idle_row_e6", 32'(row_n), 32'hFD);
            if (e == 30) check("idle_row_e30", 32'(row_n), 32'h7F);
        end

        // Quantiser: band0=00, band1=01, band2=20, band3=FF
        goto(65);
        send(64'h0000_0000_FF20_0100);
        clk1();
        check("quant_peak", peak_flat, 32'h0000_8210);
        goto(73);
        check("quant_peak_held", peak_flat, 32'h0000_8210);
        goto(89);
        check("quant_peak_decay1", peak_flat, 32'h0000_7100);
        goto(97);
        check("quant_peak_decay2", peak_flat, 32'h0000_6000);
        goto(98);
        check("quant_row0_col", 32'(col_n), 32'hF1);
        check("quant_row0_row", 32'(row_n), 32'hFE);
        goto(102);
        check("quant_row1_col", 32'(col_n), 32'hF3);
        goto(106);
        check("quant_row2_col", 32'(col_n), 32'hF7);
        goto(126);
        check("quant_row7_col", 32'(col_n), 32'hF7);

        // Hold then decay on band0
        do_reset();
        goto(1);
        send(64'h0000_0000_0000_00FF);
        send(64'h0);
        check("decay_e3", peak_flat, 32'h8);
        goto(24); check("decay_e24", peak_flat, 32'h8);
        goto(25); check("decay_e25", peak_flat, 32'h7);
        goto(33); check("decay_e33", peak_flat, 32'h6);
        goto(34); check("decay_row0_col", 32'(col_n), 32'hFF);
        goto(41); check("decay_e41", peak_flat, 32'h5);
        goto(49); check("decay_e49", peak_flat, 32'h4);
        goto(50); check("decay_row4_col", 32'(col_n), 32'hFF);
        goto(54);
        check("decay_row5_col", 32'(col_n), 32'hFE);
        check("decay_row5_row", 32'(row_n), 32'hDF);
        goto(57); check("decay_e57", peak_flat, 32'h3);
        goto(65); check("decay_e65", peak_flat, 32'h2);
        goto(73); check("decay_e73", peak_flat, 32'h1);
        goto(81); check("decay_e81", peak_flat, 32'h0);
        goto(89); check("decay_floor", peak_flat, 32'h0);

        // data_valid coinciding with tick, band0 peak=5 hold=0
        do_reset();
        goto(1);
        send(64'h80);
        clk1();
        check("sim_setup", peak_flat, 32'h5);
        goto(23);
        send(64'hA0);
        clk1();
        check("sim_new_peak", peak_flat, 32'h6);
        goto(33); check("sim_hold1", peak_flat, 32'h6);
        goto(41); check("sim_hold2", peak_flat, 32'h6);
        goto(49); check("sim_after_hold", peak_flat, 32'h5);
        goto(55);
        send(64'h40);
        clk1();
        check("sim_low_with_tick", peak_flat, 32'h4);
        goto(65); check("sim_no_reload", peak_flat, 32'h3);

        // Tear-free update mid-frame
        do_reset();
        goto(1);
        send(64'h0000_0000_0000_FF00);
        goto(49);
        send(64'h00FF_0000_0000_0000);
        clk1();
        check("tear_row4_col", 32'(col_n), 32'hFD);
        check("tear_row4_row", 32'(row_n), 32'hEF);
        goto(62);
        check("tear_row7_col", 32'(col_n), 32'hFD);
        check("tear_row7_row", 32'(row_n), 32'h7F);
        goto(65);
        check("tear_fs", 32'(frame_start), 32'h1);
        goto(66);
        check("tear_new_row0_col", 32'(col_n), 32'hBF);
        check("tear_new_row0_row", 32'(row_n), 32'hFE);
        goto(70);
        check("tear_new_row1_col", 32'(col_n), 32'hBD);

        // Reset during row 5
        goto(86);
        check("mid_pre_peak", peak_flat, 32'h0600_0000);
        check("mid_pre_row", 32'(row_n), 32'hDF);
        check("mid_pre_col", 32'(col_n), 32'hBF);
        rst = 1'b1;
        clk1();
        check("mid_rst_row", 32'(row_n), 32'hFF);
        check("mid_rst_col", 32'(col_n), 32'hFF);
        check("mid_rst_peak", peak_flat, 32'h0);
        check("mid_rst_fs", 32'(frame_start), 32'h0);
        clk1();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            clk1();
            check($sformatf("mid_dark_col_%0d", e), 32'(col_n), 32'hFF);
            if (e == 1) check("mid_restart_fs", 32'(frame_start), 32'h1);
            if (e == 2) check("mid_restart_row", 32'(row_n), 32'hFE);
            if (e == 2) check("mid_restart_peak", peak_flat, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
